rsa_io_host: RTL and testbench
==============================

RSA_IO_HOST -- requirements
Module: rsa_io_host

Interface
REQ-001 Parameter PULSE_CYC, default 4: cycles `write` is held high per word (≥3, so the debounced edge detector on the accelerator side sees it).
REQ-002 Parameter GAP_CYC, default 4: cycles `write` is held low after each pulse (≥3).
REQ-003 Parameter RST_CYC, default 4: cycles `io_rstn` is held low at the start of each transaction.
REQ-004 Parameter SETTLE_CYC, default 2: cycles `oe` is held high before `bus_in` is sampled.
REQ-005 Parameter TIMEOUT_CYC, default 65535: maximum cycles to wait for `io_end`; counter is 32 bits wide.
REQ-006 Port `clk`, input, 1 bit: single clock; all logic is on the rising edge.
REQ-007 Port `rst`, input, 1 bit: reset; one clock, reset is synchronous and active-high.
REQ-008 Port `start`, input, 1 bit: one-cycle transaction request.
REQ-009 Ports `base`, `exponent`, `modulus`, inputs, 32 bits each: operands, captured on an accepted `start`.
REQ-010 Port `io_end`, input, 1 bit: completion flag from the accelerator IO (sticky until its reset).
REQ-011 Port `bus_in`, input, 32 bits: shared data bus as read.
REQ-012 Port `bus_out`, output, 32 bits: data the host drives onto the bus.
REQ-013 Port `bus_oe`, output, 1 bit: host drive enable for the bus.
REQ-014 Port `write`, output, 1 bit: word strobe to the accelerator.
REQ-015 Port `oe`, output, 1 bit: accelerator result-drive enable.
REQ-016 Port `io_rstn`, output, 1 bit: active-low reset to the accelerator IO.
REQ-017 Port `busy`, output, 1 bit: high whenever state ≠ IDLE.
REQ-018 Port `done`, output, 1 bit: one-cycle completion pulse.
REQ-019 Port `result`, output, 32 bits: captured result, held until the next capture.
REQ-020 Port `timeout`, output, 1 bit: sticky error flag; cleared by the next accepted `start` or by `rst`.

Function
REQ-021 States SHALL be IDLE, RST_IO, SETUP, PULSE, GAP, WAIT_END, TURN, READ, DONE, ERR.
REQ-022 IDLE: `start` SHALL latch the operands and word index 0, clear `timeout`, and go to RST_IO; `start` in any other state SHALL be ignored.
REQ-023 RST_IO: `io_rstn` SHALL be 0 for exactly RST_CYC cycles, then go to SETUP.
REQ-024 Word sequence SHALL be index 0 = base, 1 = exponent, 2 = modulus, 3 = 32'h0 (arming pulse); exactly 4 write pulses SHALL be issued per transaction.
REQ-025 SETUP: 1 cycle; `bus_oe` = 1, `bus_out` = current word, `write` = 0; then go to PULSE.
REQ-026 PULSE: `write` = 1 for PULSE_CYC cycles, then go to GAP; GAP: `write` = 0 for GAP_CYC cycles.
REQ-027 In SETUP, PULSE and GAP, `bus_out` SHALL be stable; after GAP, index < 3 SHALL increment the index and go to SETUP, and index = 3 SHALL go to WAIT_END.
REQ-028 WAIT_END: `bus_oe` = 0; `io_end` = 1 SHALL go to TURN; if the wait counter reaches TIMEOUT_CYC first, go to ERR.
REQ-029 TURN: 1 dead cycle with `bus_oe` = 0 and `oe` = 0; then go to READ.
REQ-030 READ: `oe` = 1 for SETTLE_CYC cycles; `result` SHALL load `bus_in` on the last of those cycles; then go to DONE.
REQ-031 DONE: `done` = 1 for exactly 1 cycle, `oe` = 0; then go to IDLE. Latency from `start` to `done` = RST_CYC + 4·(1 + PULSE_CYC + GAP_CYC) + wait + 1 + SETTLE_CYC + 1.
REQ-032 ERR: `timeout` SHALL be set to 1, then go to IDLE; `result` SHALL remain unchanged.
REQ-033 `bus_oe` and `oe` SHALL never both be 1 in any cycle.
REQ-034 `io_end` SHALL be ignored outside WAIT_END; a stale high value is removed by RST_IO.

Reset
REQ-035 When `rst` = 1: state = IDLE, `io_rstn` = 0, `write` = 0, `oe` = 0, `bus_oe` = 0, `bus_out` = 0, `busy` = 0, `done` = 0, `timeout` = 0, `result` = 0, all counters = 0.
REQ-036 `rst` asserted mid-transaction SHALL abort it within the same edge; no further `write` pulse SHALL follow.
REQ-037 `io_rstn` SHALL be 1 in IDLE after reset.

Structure
REQ-038 A shared package SHALL hold the state enum, the word-index constants and the default timing parameters.
REQ-039 One sub-module, `cyc_timer` (loadable down-counter with zero flag), SHALL be shared by RST_IO, PULSE, GAP, WAIT_END and READ.

Verification
REQ-040 Nominal: start with base 032178C4, exponent 00000011, modulus 07A50679; IO model asserts `io_end` 100 cycles after the 4th pulse and drives 007DC743 -> bus words seen in order 032178C4, 00000011, 07A50679, 00000000; `result` = 007DC743; `done` high for 1 cycle at the latency given in REQ-031.
REQ-041 Start while busy: second `start` during PULSE -> ignored; operands and sequence unchanged.
REQ-042 Timeout with TIMEOUT_CYC = 50 and `io_end` held 0 -> `timeout` = 1 after 50 wait cycles; `result` unchanged; `done` not asserted.
REQ-043 Reset mid-PULSE of word 1 -> next cycle `write` = 0, `bus_oe` = 0, `io_rstn` = 0, `busy` = 0.
REQ-044 Back-to-back: two transactions with `io_end` left high from the first -> second transaction shows `io_rstn` low for RST_CYC cycles and reads the second result.
REQ-045 Assertion: `bus_oe` and `oe` are never both 1 across all scenarios.

Source files
------------

// File: rtl/rsa_io_host_pkg.sv
// Shared definitions for the RSA accelerator IO host: FSM states, word indices,
// default timing and the operand word selector.
package rsa_io_host_pkg;

    typedef enum logic [3:0] {
        IDLE,
        RST_IO,
        SETUP,
        PULSE,
        GAP,
        WAIT_END,
        TURN,
        READ,
        DONE,
        ERR
    } host_state_t;

    localparam logic [1:0] IDX_BASE = 2'd0;
    localparam logic [1:0] IDX_EXP  = 2'd1;
    localparam logic [1:0] IDX_MOD  = 2'd2;
    localparam logic [1:0] IDX_ARM  = 2'd3;

    localparam int DEF_PULSE_CYC   = 4;
    localparam int DEF_GAP_CYC     = 4;
    localparam int DEF_RST_CYC     = 4;
    localparam int DEF_SETTLE_CYC  = 2;
    localparam int DEF_TIMEOUT_CYC = 65535;
    localparam int TIMER_W         = 32;

    // The fourth word is all zeros; it only arms the accelerator.
    function automatic logic [31:0] select_word(
        input logic [1:0]  idx,
        input logic [31:0] b,
        input logic [31:0] e,
        input logic [31:0] m
    );
        logic [31:0] w;
        case (idx)
            IDX_BASE: w = b;
            IDX_EXP:  w = e;
            IDX_MOD:  w = m;
            default:  w = 32'h0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/rsa_io_host_cyc_timer.sv
// Loadable down-counter with a zero flag; one instance times every waiting state
// of the host FSM.
module cyc_timer #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/rsa_io_host.sv
// Host-side sequencer for the RSA accelerator IO: resets the IO, strobes four words
// over the shared bus, waits for completion, then turns the bus around and reads the result.
module rsa_io_host
    import rsa_io_host_pkg::*;
#(
    parameter int PULSE_CYC   = DEF_PULSE_CYC,
    parameter int GAP_CYC     = DEF_GAP_CYC,
    parameter int RST_CYC     = DEF_RST_CYC,
    parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] base,
    input  logic [31:0] exponent,
    input  logic [31:0] modulus,
    input  logic        io_end,
    input  logic [31:0] bus_in,
    output logic [31:0] bus_out,
    output logic        bus_oe,
    output logic        write,
    output logic        oe,
    output logic        io_rstn,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        timeout
);

    // The timer counts down to zero, so a state lasting N cycles loads N-1.
    localparam logic [TIMER_W-1:0] RST_LD     = TIMER_W'(RST_CYC - 1);
    localparam logic [TIMER_W-1:0] PULSE_LD   = TIMER_W'(PULSE_CYC - 1);
    localparam logic [TIMER_W-1:0] GAP_LD     = TIMER_W'(GAP_CYC - 1);
    localparam logic [TIMER_W-1:0] SETTLE_LD  = TIMER_W'(SETTLE_CYC - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LD = TIMER_W'(TIMEOUT_CYC - 1);

    host_state_t        state;
    logic [1:0]         word_idx;
    logic [31:0]        base_q;
    logic [31:0]        exp_q;
    logic [31:0]        mod_q;
    logic               tmr_load;
    logic [TIMER_W-1:0] tmr_val;
    logic               tmr_zero;

    cyc_timer #(
        .W(TIMER_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // Load the timer on the edge that enters a timed state, matching the FSM below.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state)
            IDLE: begin
                tmr_load = start;
                tmr_val  = RST_LD;
            end
            SETUP: begin
                tmr_load = 1'b1;
                tmr_val  = PULSE_LD;
            end
            PULSE: begin
                tmr_load = tmr_zero;
                tmr_val  = GAP_LD;
            end
            GAP: begin
                tmr_load = tmr_zero && (word_idx == IDX_ARM);
                tmr_val  = TIMEOUT_LD;
            end
            TURN: begin
                tmr_load = 1'b1;
                tmr_val  = SETTLE_LD;
            end
            default: begin
                tmr_load = 1'b0;
                tmr_val  = '0;
            end
        endcase
    end

    // All outputs are set on the transition into the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            io_rstn  <= 1'b0;
            write    <= 1'b0;
            oe       <= 1'b0;
            bus_oe   <= 1'b0;
            bus_out  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            timeout  <= 1'b0;
            result   <= '0;
            word_idx <= IDX_BASE;
            base_q   <= '0;
            exp_q    <= '0;
            mod_q    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    io_rstn <= 1'b1;
                    if (start) begin
                        base_q   <= base;
                        exp_q    <= exponent;
                        mod_q    <= modulus;
                        word_idx <= IDX_BASE;
                        timeout  <= 1'b0;
                        io_rstn  <= 1'b0;
                        busy     <= 1'b1;
                        state    <= RST_IO;
                    end
                end
                RST_IO: begin
                    if (tmr_zero) begin
                        io_rstn <= 1'b1;
                        bus_oe  <= 1'b1;
                        bus_out <= select_word(word_idx, base_q, exp_q, mod_q);
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    write <= 1'b1;
                    state <= PULSE;
                end
                PULSE: begin
                    if (tmr_zero) begin
                        write <= 1'b0;
                        state <= GAP;
                    end
                end
                GAP: begin
                    if (tmr_zero) begin
                        if (word_idx == IDX_ARM) begin
                            bus_oe <= 1'b0;
                            state  <= WAIT_END;
                        end else begin
                            word_idx <= word_idx + 2'd1;
                            bus_out  <= select_word(word_idx + 2'd1, base_q, exp_q, mod_q);
                            state    <= SETUP;
                        end
                    end
                end
                WAIT_END: begin
                    if (io_end) begin
                        state <= TURN;
                    end else if (tmr_zero) begin
                        timeout <= 1'b1;
                        state   <= ERR;
                    end
                end
                TURN: begin
                    oe    <= 1'b1;
                    state <= READ;
                end
                READ: begin
                    if (tmr_zero) begin
                        result <= bus_in;
                        oe     <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                ERR: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_io_host.sv
// Directed bench for rsa_io_host: a behavioural accelerator IO model feeds one default
// instance, and a second instance with a short timeout is left waiting for io_end forever.
module tb_rsa_io_host;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        start_to;
    logic [31:0] base;
    logic [31:0] exponent;
    logic [31:0] modulus;
    logic        io_end = 1'b0;
    logic        io_end_to = 1'b0;
    logic [31:0] io_result = 32'h0;
    logic [31:0] bus_in;
    logic [31:0] bus_in_to;

    logic [31:0] bus_out, bus_out_to;
    logic        bus_oe, bus_oe_to;
    logic        write, write_to;
    logic        oe, oe_to;
    logic        io_rstn, io_rstn_to;
    logic        busy, busy_to;
    logic        done, done_to;
    logic [31:0] result, result_to;
    logic        timeout, timeout_to;

    int n_cmp = 0;
    int n_bad = 0;
    int conflicts = 0;
    int bus_oe_miss = 0;
    int done_to_seen = 0;

    logic [31:0] seen_words[$];
    logic        write_q = 1'b0;
    int          pulse_cnt = 0;
    int          end_cd = 0;

    always #5 clk = ~clk;

    assign bus_in    = (oe === 1'b1) ? io_result : 32'h0;
    assign bus_in_to = 32'h0;

    rsa_io_host dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .base     (base),
        .exponent (exponent),
        .modulus  (modulus),
        .io_end   (io_end),
        .bus_in   (bus_in),
        .bus_out  (bus_out),
        .bus_oe   (bus_oe),
        .write    (write),
        .oe       (oe),
        .io_rstn  (io_rstn),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .timeout  (timeout)
    );

    rsa_io_host #(
        .TIMEOUT_CYC(50)
    ) dut_to (
        .clk      (clk),
        .rst      (rst),
        .start    (start_to),
        .base     (base),
        .exponent (exponent),
        .modulus  (modulus),
        .io_end   (io_end_to),
        .bus_in   (bus_in_to),
        .bus_out  (bus_out_to),
        .bus_oe   (bus_oe_to),
        .write    (write_to),
        .oe       (oe_to),
        .io_rstn  (io_rstn_to),
        .busy     (busy_to),
        .done     (done_to),
        .result   (result_to),
        .timeout  (timeout_to)
    );

    // Accelerator IO model: latch each word on the rising write, raise io_end 100 cycles
    // after the fourth pulse falls, and forget everything while io_rstn is low.
    always @(negedge clk) begin
        if (io_rstn === 1'b0) begin
            io_end    = 1'b0;
            pulse_cnt = 0;
            end_cd    = 0;
        end else begin
            if (write === 1'b1 && write_q === 1'b0) begin
                seen_words.push_back(bus_out);
                if (bus_oe !== 1'b1) bus_oe_miss++;
            end
            if (write === 1'b0 && write_q === 1'b1) begin
                pulse_cnt++;
                if (pulse_cnt == 4) end_cd = 100;
            end else if (end_cd == 1) begin
                io_end = 1'b1;
                end_cd = 0;
            end else if (end_cd > 1) begin
                end_cd--;
            end
        end
        write_q = write;
    end

    always @(negedge clk) begin
        if (bus_oe === 1'b1 && oe === 1'b1) conflicts++;
        if (bus_oe_to === 1'b1 && oe_to === 1'b1) conflicts++;
        if (done_to === 1'b1) done_to_seen++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_cmp++;
        if (got !== expv) begin
            n_bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, expv);
        end
    endtask

    // Called at a negedge with the DUT idle; returns the number of rising edges until done
    // is seen (0 if it never comes) and how many sampled cycles had io_rstn low.
    task automatic applyStimulus(
        input  logic [31:0] b,
        input  logic [31:0] e,
        input  logic [31:0] m,
        input  logic [31:0] r,
        input  bit          poke_busy,
        output int          lat,
        output int          rstn_low,
        output int          wb
    );
        wb        = seen_words.size();
        io_result = r;
        base      = b;
        exponent  = e;
        modulus   = m;
        start     = 1'b1;
        lat       = 0;
        rstn_low  = 0;
        for (int c = 1; c <= 1000; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (io_rstn === 1'b0) rstn_low++;
            if (poke_busy && c == 7) begin
                start    = 1'b1;
                base     = 32'hFFFF_0000;
                exponent = 32'h1234_5678;
                modulus  = 32'hAAAA_5555;
            end
            if (done === 1'b1) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic checkWords(input int wb, input logic [31:0] b, input logic [31:0] e,
                              input logic [31:0] m);
        logic [31:0] expw [4];
        logic [31:0] got;
        expw[0] = b;
        expw[1] = e;
        expw[2] = m;
        expw[3] = 32'h0;
        checkOutput("word_count", 32'(seen_words.size() - wb), 32'd4);
        for (int i = 0; i < 4; i++) begin
            got = (wb + i < seen_words.size()) ? seen_words[wb + i] : 32'hDEAD_DEAD;
            checkOutput($sformatf("word%0d", i), got, expw[i]);
        end
    endtask

    int lat;
    int rstn_low;
    int wb;
    int tmo_at;

    // Nominal latency: RST 4 + 4*(1+4+4) + wait 97 + TURN 1 + READ 2 + DONE edge 1 = 141,
    // where io_end rises 100 cycles after the last write falls and 3 of those lie in GAP.
    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        start_to = 1'b0;
        base     = 32'h0;
        exponent = 32'h0;
        modulus  = 32'h0;
        repeat (2) @(negedge clk);
        checkOutput("rst_busy", busy, 32'd0);
        checkOutput("rst_write", write, 32'd0);
        checkOutput("rst_oe", oe, 32'd0);
        checkOutput("rst_bus_oe", bus_oe, 32'd0);
        checkOutput("rst_bus_out", bus_out, 32'h0);
        checkOutput("rst_io_rstn", io_rstn, 32'd0);
        checkOutput("rst_done", done, 32'd0);
        checkOutput("rst_timeout", timeout, 32'd0);
        checkOutput("rst_result", result, 32'h0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("idle_io_rstn", io_rstn, 32'd1);
        checkOutput("idle_busy", busy, 32'd0);

        $display("[TB] nominal transaction with a second start during PULSE");
        applyStimulus(32'h032178C4, 32'h00000011, 32'h07A50679, 32'h007DC743, 1'b1,
                      lat, rstn_low, wb);
        checkOutput("nom_latency", lat, 32'd141);
        checkOutput("nom_rstn_low", rstn_low, 32'd4);
        checkOutput("nom_result", result, 32'h007DC743);
        checkOutput("nom_busy_in_done", busy, 32'd1);
        checkWords(wb, 32'h032178C4, 32'h00000011, 32'h07A50679);
        @(negedge clk);
        checkOutput("nom_done_width", done, 32'd0);
        checkOutput("nom_busy_after", busy, 32'd0);
        checkOutput("nom_result_held", result, 32'h007DC743);

        $display("[TB] back-to-back transaction with io_end still high");
        applyStimulus(32'h00000007, 32'h00000003, 32'h0000000D, 32'h00C0FFEE, 1'b0,
                      lat, rstn_low, wb);
        checkOutput("b2b_latency", lat, 32'd141);
        checkOutput("b2b_rstn_low", rstn_low, 32'd4);
        checkOutput("b2b_result", result, 32'h00C0FFEE);
        checkWords(wb, 32'h00000007, 32'h00000003, 32'h0000000D);
        @(negedge clk);
        checkOutput("b2b_done_width", done, 32'd0);

        $display("[TB] reset during PULSE of word 1");
        wb       = seen_words.size();
        base     = 32'h01010101;
        exponent = 32'h02020202;
        modulus  = 32'h03030303;
        start    = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        checkOutput("pre_reset_write", write, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort_write", write, 32'd0);
        checkOutput("abort_bus_oe", bus_oe, 32'd0);
        checkOutput("abort_io_rstn", io_rstn, 32'd0);
        checkOutput("abort_busy", busy, 32'd0);
        checkOutput("abort_result", result, 32'h0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        checkOutput("abort_pulses", 32'(seen_words.size() - wb), 32'd2);
        checkOutput("abort_idle_io_rstn", io_rstn, 32'd1);

        // Timeout: RST 4 + words 36 + WAIT_END 50 -> ERR entered on the 91st edge.
        $display("[TB] timeout with io_end held low");
        start_to = 1'b1;
        tmo_at   = 0;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            start_to = 1'b0;
            if (timeout_to === 1'b1) begin
                tmo_at = c;
                break;
            end
        end
        checkOutput("tmo_latency", tmo_at, 32'd91);
        @(negedge clk);
        checkOutput("tmo_busy_after", busy_to, 32'd0);
        checkOutput("tmo_sticky", timeout_to, 32'd1);
        checkOutput("tmo_result", result_to, 32'h0);
        checkOutput("tmo_no_done", done_to_seen, 32'd0);
        start_to = 1'b1;
        @(negedge clk);
        start_to = 1'b0;
        checkOutput("tmo_cleared_by_start", timeout_to, 32'd0);
        checkOutput("tmo_busy_restart", busy_to, 32'd1);

        checkOutput("bus_oe_oe_exclusive", conflicts, 32'd0);
        checkOutput("bus_oe_at_write", bus_oe_miss, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
